// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: asserts NUM_CH active-low channel resets at once, then releases
// them one at a time after a synchronised, stretched master-reset deassertion.
module rst_seq_ctrl #(
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int STRETCH     = 8,
    parameter int GAP         = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sw_rst_req,
    input  logic [NUM_CH-1:0] hold,
    output logic [NUM_CH-1:0] rst_n_out,
    output logic              busy,
    output logic              seq_done,
    output logic [1:0]        dbg_state
);

    localparam int MAX_CNT = (STRETCH > GAP) ? STRETCH : GAP;
    localparam int CNT_W   = $clog2(MAX_CNT) + 1;
    localparam int IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [1:0] S_ASSERT  = 2'd0;
    localparam logic [1:0] S_RELEASE = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [1:0]             r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [IDX_W-1:0]       r_idx;
    logic [NUM_CH-1:0]      r_rst_n;
    logic                   r_busy;
    logic                   r_done;

    logic                   w_rst_sync;
    logic                   w_hold_idx;
    logic                   w_last;
    logic                   w_due;
    logic                   w_counting;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b0};
        end
    end

    assign w_rst_sync = r_sync[SYNC_STAGES-1];
    assign w_hold_idx = hold[r_idx];
    assign w_last     = (r_idx == IDX_W'(NUM_CH - 1));

    // r_cnt holds the number of edges already spent in the current wait, so a
    // channel is due on the edge where r_cnt reaches STRETCH (first) or GAP.
    always_comb begin
        w_due      = 1'b0;
        w_counting = 1'b0;
        case (r_state)
            S_ASSERT: begin
                w_counting = !w_rst_sync;
                w_due      = !w_rst_sync && (r_cnt == CNT_W'(STRETCH));
            end
            S_RELEASE: begin
                w_counting = 1'b1;
                w_due      = (r_cnt == CNT_W'(GAP));
            end
            default: begin
                w_counting = 1'b0;
                w_due      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_ASSERT;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_rst_n <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
        end else if (sw_rst_req) begin
            // The request edge itself counts as the first stretch cycle.
            r_state <= S_ASSERT;
            r_cnt   <= w_rst_sync ? CNT_W'(0) : CNT_W'(1);
            r_idx   <= '0;
            r_rst_n <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
        end else if (r_state == S_DONE) begin
            r_rst_n <= ~hold;
            r_busy  <= |hold;
        end else if (w_due) begin
            // A held channel stalls the sequence with the counter frozen.
            if (!w_hold_idx) begin
                r_rst_n[r_idx] <= 1'b1;
                r_cnt          <= CNT_W'(1);
                if (w_last) begin
                    r_state <= S_DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end else begin
                    r_state <= S_RELEASE;
                    r_idx   <= r_idx + IDX_W'(1);
                end
            end
        end else if (w_counting) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign rst_n_out = r_rst_n;
    assign busy      = r_busy;
    assign seq_done  = r_done;
    assign dbg_state = r_state;

endmodule

// File: doc/rst_seq_ctrl.md
Name: rst_seq_ctrl

Overview:
- Parametrised reset sequencer that generates NUM_CH active-low channel resets from one clock and one asynchronous active-high master reset.
- Channel resets assert immediately; deassertion is synchronised, stretched, then released one channel at a time in index order with a programmable gap.
- Supports a synchronous software reset request and per-channel hold-in-reset.
- Sits between the testbench/board reset source and DUT reset inputs, replacing the single fixed rst_n interface signal.

Parameters:
- NUM_CH, 4, number of channel reset outputs (1..16)
- SYNC_STAGES, 2, flops in the master-reset deassertion synchroniser (>=2)
- STRETCH, 8, cycles all channels stay asserted after the synchronised release (>=1)
- GAP, 4, cycles between consecutive channel releases (>=1)
- CNT_W, $clog2(max(STRETCH,GAP))+1, internal counter width (derived, not overridden)

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high master reset
- sw_rst_req  input  1  single-cycle synchronous request to restart the full sequence
- hold  input  NUM_CH  per-channel hold-in-reset, synchronous to clk
- rst_n_out  output  NUM_CH  active-low channel resets; bit k is channel k
- busy  output  1  high while any channel is held in reset by the sequencer
- seq_done  output  1  high once all channels have been released

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- rst high: rst_n_out=all 0, busy=1, seq_done=0 asynchronously. Synchroniser, counters and FSM are cleared; FSM goes to ASSERT.
- Deassertion synchroniser: rst falls, then an internal rst_sync falls on the SYNC_STAGES-th posedge. Edge E0 is the first posedge with rst low.
- FSM states:
  - ASSERT: entered on rst_sync, or on sw_rst_req from any state. All outputs are asserted and the counter counts STRETCH cycles. Then go to RELEASE with idx=0.
  - RELEASE: rst_n_out[idx] goes high on entry. Wait GAP cycles, then idx++. When idx=NUM_CH-1 is released, go to DONE.
  - DONE: seq_done=1, busy=0.
- Release timing, counting from E0 as edge 0: channel k goes high at edge SYNC_STAGES+STRETCH+k*GAP. seq_done and busy change on the same edge as the last channel.
- Hold in the sequence: if hold[idx]=1 when channel idx is due, the FSM stalls with the counter frozen. The channel releases on the first edge where hold[idx]=0. All subsequent channels shift by the stall length.
- Hold in DONE: hold[k]=1 drives rst_n_out[k]=0 on the next edge. It releases on the edge after hold[k] falls. seq_done stays 1 and busy goes 1 while any hold is active.
- Software reset: sw_rst_req=1 on edge N drives all rst_n_out to 0 and seq_done to 0 at edge N, restarting ASSERT. Channel 0 releases at N+STRETCH. A request during ASSERT restarts the stretch count.
- rst mid-sequence: everything aborts asynchronously and the full timing restarts from E0.
- Simultaneous rst and sw_rst_req: rst dominates. Simultaneous sw_rst_req and a channel release edge: the request wins and no channel is released.
- Glitch-free outputs: each rst_n_out bit is driven directly from a flop, asynchronously cleared by rst.
- Monotonic release: a released channel never re-asserts except via rst, sw_rst_req, or its own hold in DONE.
- NUM_CH=1: DONE is entered on the channel-0 release edge.

Test Plan:
- Power-on, defaults, rst high for 5 cycles then low (E0): rst_n_out=0000 until edge 10, then 0001@10, 0011@14, 0111@18, 1111@22; seq_done=1 and busy=0 at edge 22.
- rst pulsed high at edge 15, mid-sequence: rst_n_out=0000 immediately (async). After release, timing restarts from the new E0 (ch0 at +10).
- sw_rst_req pulse at edge 40, in DONE: rst_n_out=0000 and seq_done=0 at edge 40; ch0 at 48, ch1 52, ch2 56, ch3 60.
- hold[1]=1 from edge 0 until edge 20: ch0 at 10, ch1 at 20, ch2 at 24, ch3 at 28.
- In DONE, hold[2]=1 for cycles 50–53: rst_n_out[2]=0 and busy=1 from edge 51; bit 2 back to 1 at edge 55; other bits stay 1 and seq_done stays 1.
- NUM_CH=8, GAP=1, STRETCH=1, SYNC_STAGES=3: channels release at edges 4..11, one per cycle. sw_rst_req and rst asserted on the same edge: async reset path taken.
